vga_rect_filler: RTL and testbench

//  Sequential producer for the DESim "VGA" pixel-plot interface (VGA_X, VGA_Y, VGA_COLOR, plot).

---
 rtl/vga_rect_filler.sv | 169 ++++++++++++++++
 tb/tb_vga_rect_filler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine for the DESim VGA pixel-plot port: one request in, one pixel write per clock out.
// Optional outline-only drawing is enabled by defining RECT_OUTLINE_EN.
module vga_rect_filler #(
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int COLOR_W = 3,
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [X_W-1:0]     req_x,
   input  logic [Y_W-1:0]     req_y,
   input  logic [X_W-1:0]     req_w,
   input  logic [Y_W-1:0]     req_h,
   input  logic [COLOR_W-1:0] req_color,
`ifdef RECT_OUTLINE_EN
   input  logic               req_outline,
`endif
   output logic               busy,
   output logic               done,
   output logic [X_W-1:0]     VGA_X,
   output logic [Y_W-1:0]     VGA_Y,
   output logic [COLOR_W-1:0] VGA_COLOR,
   output logic               plot
);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
   typedef logic [X_W:0] xext_t;
   typedef logic [Y_W:0] yext_t;

   localparam xext_t XLimit = xext_t'(X_MAX);
   localparam yext_t YLimit = yext_t'(Y_MAX);

   state_t               state_q, state_d;
   xext_t                cursorX_q, cursorX_d;
   yext_t                cursorY_q, cursorY_d;
   logic [X_W-1:0]       orgX_q, orgW_q, effX, effW;
   logic [Y_W-1:0]       orgY_q, orgH_q, effY, effH;
   logic [COLOR_W-1:0]   color_q, effColor;
   logic [X_W-1:0]       vgaX_q;
   logic [Y_W-1:0]       vgaY_q;
   logic [COLOR_W-1:0]   vgaColor_q;
   logic                 plot_q, plot_d, done_q;
   logic                 accept, pixelNext, inRange;
   xext_t                endX;
   yext_t                endY;

   assign accept    = req_valid && (state_q == IDLE);
   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign plot      = plot_q;
   assign VGA_X     = vgaX_q;
   assign VGA_Y     = vgaY_q;
   assign VGA_COLOR = vgaColor_q;

   // On the accept edge the request ports are used directly, so the first pixel needs no extra cycle.
   always_comb begin
      effX     = orgX_q;
      effY     = orgY_q;
      effW     = orgW_q;
      effH     = orgH_q;
      effColor = color_q;
      if (accept) begin
         effX     = req_x;
         effY     = req_y;
         effW     = req_w;
         effH     = req_h;
         effColor = req_color;
      end
      endX = xext_t'(effX) + xext_t'(effW) - xext_t'(1);
      endY = yext_t'(effY) + yext_t'(effH) - yext_t'(1);
   end

   always_comb begin
      state_d   = state_q;
      cursorX_d = cursorX_q;
      cursorY_d = cursorY_q;
      pixelNext = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_w != '0 && req_h != '0) begin
                  state_d   = DRAW;
                  cursorX_d = xext_t'(req_x);
                  cursorY_d = yext_t'(req_y);
                  pixelNext = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DRAW: begin
            if (cursorX_q == endX) begin
               if (cursorY_q == endY) begin
                  state_d = DONE;
               end else begin
                  cursorX_d = xext_t'(effX);
                  cursorY_d = cursorY_q + yext_t'(1);
                  pixelNext = 1'b1;
               end
            end else begin
               cursorX_d = cursorX_q + xext_t'(1);
               pixelNext = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Cursor is one bit wider than the screen so x0+w never wraps back into range.
   assign inRange = (cursorX_d <= XLimit) && (cursorY_d <= YLimit);

`ifdef RECT_OUTLINE_EN
   logic outline_q, effOutline, onBorder;
   assign effOutline = accept ? req_outline : outline_q;
   assign onBorder   = (cursorX_d == xext_t'(effX)) || (cursorX_d == endX) ||
                       (cursorY_d == yext_t'(effY)) || (cursorY_d == endY);
   assign plot_d     = pixelNext && inRange && (!effOutline || onBorder);

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)     outline_q <= 1'b0;
      else if (accept) outline_q <= req_outline;
   end
`else
   assign plot_d = pixelNext && inRange;
`endif

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cursorX_q  <= '0;
         cursorY_q  <= '0;
         orgX_q     <= '0;
         orgY_q     <= '0;
         orgW_q     <= '0;
         orgH_q     <= '0;
         color_q    <= '0;
         plot_q     <= 1'b0;
         done_q     <= 1'b0;
         vgaX_q     <= '0;
         vgaY_q     <= '0;
         vgaColor_q <= '0;
      end else begin
         state_q   <= state_d;
         cursorX_q <= cursorX_d;
         cursorY_q <= cursorY_d;
         plot_q    <= plot_d;
         done_q    <= (state_d == DONE);
         if (accept) begin
            orgX_q  <= req_x;
            orgY_q  <= req_y;
            orgW_q  <= req_w;
            orgH_q  <= req_h;
            color_q <= req_color;
         end
         if (plot_d) begin
            vgaX_q     <= cursorX_d[X_W-1:0];
            vgaY_q     <= cursorY_d[Y_W-1:0];
            vgaColor_q <= effColor;
         end
      end
   end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Self-checking bench for vga_rect_filler: a per-cycle expectation queue built from each accepted request,
// checked every cycle, plus directed literal expectations for the classic scenarios.
module tb_vga_rect_filler;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_x = '0;
   logic [6:0] req_y = '0;
   logic [7:0] req_w = '0;
   logic [6:0] req_h = '0;
   logic [2:0] req_color = '0;
`ifdef RECT_OUTLINE_EN
   logic       req_outline = 1'b0;
`endif
   logic       busy, done, plot;
   logic [7:0] VGA_X;
   logic [6:0] VGA_Y;
   logic [2:0] VGA_COLOR;

   vga_rect_filler dut (
      .CLOCK_50(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_color(req_color),
`ifdef RECT_OUTLINE_EN
      .req_outline(req_outline),
`endif
      .busy(busy), .done(done), .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit plot;
      int x;
      int y;
      int color;
      bit done;
   } exp_t;

   exp_t expQ[$];
   int   mLastX = 0, mLastY = 0, mLastColor = 0;
   int   testsRun = 0, testsFailed = 0;
   bit   checkEn = 1'b0;
   bit   wasIdle;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // One expectation entry per cycle the block is busy: every pixel of the rectangle, then the done cycle.
   function automatic void pushRequest(input int x, input int y, input int w, input int h,
                                       input int color, input bit outline);
      exp_t e;
      if (w > 0 && h > 0) begin
         for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
               bit border;
               border = (c == 0) || (c == w - 1) || (r == 0) || (r == h - 1);
               e.plot = ((x + c) <= 159) && ((y + r) <= 119) && (!outline || border);
               if (e.plot) begin
                  mLastX     = x + c;
                  mLastY     = y + r;
                  mLastColor = color;
               end
               e.x = mLastX; e.y = mLastY; e.color = mLastColor; e.done = 1'b0;
               expQ.push_back(e);
            end
         end
      end
      e.plot = 1'b0; e.x = mLastX; e.y = mLastY; e.color = mLastColor; e.done = 1'b1;
      expQ.push_back(e);
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         expQ.delete();
         mLastX = 0; mLastY = 0; mLastColor = 0;
      end else begin
         wasIdle = (expQ.size() == 0);
         if (!wasIdle) void'(expQ.pop_front());
         if (wasIdle && req_valid)
`ifdef RECT_OUTLINE_EN
            pushRequest(req_x, req_y, req_w, req_h, req_color, req_outline);
`else
            pushRequest(req_x, req_y, req_w, req_h, req_color, 1'b0);
`endif
      end
   end

   always @(negedge clk) begin
      exp_t e;
      bit   active;
      if (checkEn) begin
         active = (expQ.size() != 0);
         if (active) e = expQ[0];
         else begin
            e.plot = 1'b0; e.x = mLastX; e.y = mLastY; e.color = mLastColor; e.done = 1'b0;
         end
         checkOutput("cyc_plot", plot, e.plot);
         checkOutput("cyc_done", done, e.done);
         checkOutput("cyc_busy", busy, active);
         checkOutput("cyc_ready", req_ready, !active);
         checkOutput("cyc_vga_x", VGA_X, e.x);
         checkOutput("cyc_vga_y", VGA_Y, e.y);
         checkOutput("cyc_vga_color", VGA_COLOR, e.color);
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle right after the accept edge.
   task automatic applyStimulus(input int x, input int y, input int w, input int h,
                                input int color, input bit outline);
      int guard = 0;
      while (!req_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!req_ready) checkOutput("ready_timeout", req_ready, 1);
      req_x = 8'(x); req_y = 7'(y); req_w = 8'(w); req_h = 7'(h); req_color = 3'(color);
`ifdef RECT_OUTLINE_EN
      req_outline = outline;
`else
      if (outline) $display("[TB] outline request ignored in this build");
`endif
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic runUntilDone(input string tag, input int maxCycles, output int plots, output int cycles);
      plots = 0;
      cycles = 0;
      forever begin
         @(negedge clk);
         if (done) break;
         cycles++;
         if (plot) plots++;
         if (cycles > maxCycles) begin
            checkOutput({tag, "_done_timeout"}, cycles, maxCycles);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   int plots, cycles;
   int t1x[6] = '{2, 3, 4, 2, 3, 4};
   int t1y[6] = '{3, 3, 3, 4, 4, 4};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkEn = 1'b1;
      checkOutput("rst_ready", req_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_plot", plot, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_vga_x", VGA_X, 0);
      #3 resetn = 1'b1;
      @(posedge clk); #1;

      // Test 1: 3x2 rectangle, pixels in row-major order, done then ready
      applyStimulus(2, 3, 3, 2, 5, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("t1_plot", plot, 1);
         checkOutput("t1_x", VGA_X, t1x[k]);
         checkOutput("t1_y", VGA_Y, t1y[k]);
         checkOutput("t1_color", VGA_COLOR, 5);
      end
      @(negedge clk);
      checkOutput("t1_done", done, 1);
      checkOutput("t1_done_ready", req_ready, 0);
      @(negedge clk);
      checkOutput("t1_ready", req_ready, 1);
      checkOutput("t1_done_clear", done, 0);
      @(posedge clk); #1;

      // Test 2: empty rectangle
      applyStimulus(7, 7, 0, 9, 2, 1'b0);
      @(negedge clk);
      checkOutput("t2_done", done, 1);
      checkOutput("t2_plot", plot, 0);
      @(negedge clk);
      checkOutput("t2_ready", req_ready, 1);
      checkOutput("t2_hold_x", VGA_X, 4);
      @(posedge clk); #1;

      // Test 3: straddles the bottom-right corner
      applyStimulus(158, 119, 4, 2, 6, 1'b0);
      runUntilDone("t3", 50, plots, cycles);
      checkOutput("t3_cycles", cycles, 8);
      checkOutput("t3_plots", plots, 2);
      checkOutput("t3_last_x", VGA_X, 159);

      // Test 4: fully off-screen, end coordinate beyond 255 must not wrap
      applyStimulus(250, 10, 10, 2, 1, 1'b0);
      runUntilDone("t4", 50, plots, cycles);
      checkOutput("t4_cycles", cycles, 20);
      checkOutput("t4_plots", plots, 0);

      // Bottom rows clipped
      applyStimulus(100, 118, 2, 3, 4, 1'b0);
      runUntilDone("clip_rows", 50, plots, cycles);
      checkOutput("clip_rows_cycles", cycles, 6);
      checkOutput("clip_rows_plots", plots, 4);

      // Single pixel on the last visible position
      applyStimulus(159, 119, 1, 1, 7, 1'b0);
      runUntilDone("corner", 10, plots, cycles);
      checkOutput("corner_cycles", cycles, 1);
      checkOutput("corner_plots", plots, 1);
      checkOutput("corner_y", VGA_Y, 119);

      // Test 5: asynchronous reset on the third pixel of a 4x4
      applyStimulus(20, 30, 4, 4, 2, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      checkOutput("t5_pre_plot", plot, 1);
      checkOutput("t5_pre_x", VGA_X, 22);
      resetn = 1'b0;
      #1;
      checkOutput("t5_plot_drop", plot, 0);
      checkOutput("t5_busy_drop", busy, 0);
      checkOutput("t5_no_done", done, 0);
      checkOutput("t5_x_cleared", VGA_X, 0);
      @(negedge clk);
      @(negedge clk);
      #2 resetn = 1'b1;
      @(posedge clk); #1;
      checkOutput("t5_no_done_after", done, 0);
      applyStimulus(5, 6, 2, 1, 3, 1'b0);
      runUntilDone("t5_next", 10, plots, cycles);
      checkOutput("t5_next_cycles", cycles, 2);
      checkOutput("t5_next_plots", plots, 2);

      // Valid held high: requests during DRAW/DONE are ignored, re-accepted only from IDLE
      req_x = 8'd10; req_y = 7'd10; req_w = 8'd2; req_h = 7'd2; req_color = 3'd6;
`ifdef RECT_OUTLINE_EN
      req_outline = 1'b0;
`endif
      req_valid = 1'b1;
      repeat (14) @(posedge clk);
      #1 req_valid = 1'b0;
      begin
         int g = 0;
         while (expQ.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
         end
         if (expQ.size() != 0) checkOutput("hold_drain_timeout", expQ.size(), 0);
      end
      @(negedge clk);
      checkOutput("hold_last_x", VGA_X, 11);
      checkOutput("hold_last_y", VGA_Y, 11);
      checkOutput("hold_last_color", VGA_COLOR, 6);
      @(posedge clk); #1;

`ifdef RECT_OUTLINE_EN
      // Test 6: outline-only 4x4
      applyStimulus(40, 50, 4, 4, 3, 1'b1);
      runUntilDone("t6", 40, plots, cycles);
      checkOutput("t6_cycles", cycles, 16);
      checkOutput("t6_plots", plots, 12);
      applyStimulus(40, 50, 4, 4, 3, 1'b0);
      runUntilDone("t6_fill", 40, plots, cycles);
      checkOutput("t6_fill_plots", plots, 16);
`endif

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
